dac_spi_tx: RTL

//  Parametrised SPI serializer for 3-wire serial DACs (DAC8811 class), generalising the fixed 16-bit driver.

---
 rtl/dac_spi_tx_if.sv | 12 +
 rtl/dac_spi_tx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx_if.sv
// Parallel sample handshake into the DAC serializer: the source (master) offers din with din_valid,
// and the serializer (slave) raises din_ready only while it is idle.
interface dac_spi_tx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/dac_spi_tx.sv
// MSB-first 3-wire SPI serializer for DAC8811-class DACs with programmable SCLK divider and CS gap.
// Optional active-low LDAC strobe inside the CS-high gap is built when DAC_SPI_LDAC_EN is defined.
module dac_spi_tx #(
  parameter int DATA_W = 16,
  parameter int DIV    = 11,
  parameter int GAP    = 2
) (
  input  logic         clk,
  input  logic         rst,
  dac_spi_tx_if.slave  s_in,
  output logic         busy,
  output logic         frame_done,
  output logic         CS,
  output logic         SCLK,
  output logic         SerialData
`ifdef DAC_SPI_LDAC_EN
  ,
  output logic         LDAC
`endif
);

  localparam int HW   = $clog2(DIV + 1);
  localparam int BW   = $clog2(DATA_W + 1);
  // The IDLE cycle closes the CS-high gap, so the GAP state itself runs one cycle short.
  localparam int GCYC = GAP * DIV - 1;
  localparam int GW   = $clog2(GCYC + 1);

  localparam logic [HW-1:0] HC_LAST = HW'(DIV - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(DATA_W - 1);
  localparam logic [GW-1:0] GC_LAST = GW'(GCYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t            state_reg, state_next;
  logic [HW-1:0]     hcnt_reg, hcnt_next;
  logic [BW-1:0]     bcnt_reg, bcnt_next;
  logic [GW-1:0]     gcnt_reg, gcnt_next;
  logic [DATA_W-1:0] shreg_reg, shreg_next, shifted;
  logic              cs_reg, cs_next;
  logic              sclk_reg, sclk_next;
  logic              sdo_reg, sdo_next;
  logic              busy_reg, busy_next;
  logic              fd_reg, fd_next;
  logic              accept, half_last, bit_last, gap_last;

  assign s_in.din_ready = (state_reg == S_IDLE);
  assign accept         = s_in.din_valid && (state_reg == S_IDLE);
  assign half_last      = (hcnt_reg == HC_LAST);
  assign bit_last       = (bcnt_reg == BC_LAST);
  assign gap_last       = (gcnt_reg == GC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      hcnt_reg  <= '0;
      bcnt_reg  <= '0;
      gcnt_reg  <= '0;
      shreg_reg <= '0;
      cs_reg    <= 1'b1;
      sclk_reg  <= 1'b1;
      sdo_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      fd_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      hcnt_reg  <= hcnt_next;
      bcnt_reg  <= bcnt_next;
      gcnt_reg  <= gcnt_next;
      shreg_reg <= shreg_next;
      cs_reg    <= cs_next;
      sclk_reg  <= sclk_next;
      sdo_reg   <= sdo_next;
      busy_reg  <= busy_next;
      fd_reg    <= fd_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_SETUP;
      S_SETUP: if (half_last) state_next = S_SHIFT;
      S_SHIFT: if (half_last && sclk_reg && bit_last) state_next = S_HOLD;
      S_HOLD:  if (half_last) state_next = S_GAP;
      S_GAP:   if (gap_last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    hcnt_next  = '0;
    bcnt_next  = bcnt_reg;
    gcnt_next  = '0;
    shreg_next = shreg_reg;
    shifted    = shreg_reg << 1;
    cs_next    = cs_reg;
    sclk_next  = sclk_reg;
    sdo_next   = sdo_reg;
    fd_next    = 1'b0;
    busy_next  = (state_next != S_IDLE);
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          shreg_next = s_in.din;
          cs_next    = 1'b0;
          sclk_next  = 1'b1;
          sdo_next   = s_in.din[DATA_W-1];
          bcnt_next  = '0;
        end
      end
      S_SETUP: begin
        hcnt_next = half_last ? '0 : hcnt_reg + HW'(1);
        if (half_last) sclk_next = 1'b0;
      end
      S_SHIFT: begin
        hcnt_next = half_last ? '0 : hcnt_reg + HW'(1);
        if (half_last) begin
          if (!sclk_reg) begin
            sclk_next = 1'b1;
          end else if (!bit_last) begin
            // Falling edge into the next bit: data moves while SCLK is low.
            sclk_next  = 1'b0;
            bcnt_next  = bcnt_reg + BW'(1);
            shreg_next = shifted;
            sdo_next   = shifted[DATA_W-1];
          end
        end
      end
      S_HOLD: begin
        hcnt_next = half_last ? '0 : hcnt_reg + HW'(1);
        if (half_last) begin
          cs_next  = 1'b1;
          sdo_next = 1'b0;
          fd_next  = 1'b1;
        end
      end
      S_GAP: begin
        gcnt_next = gap_last ? '0 : gcnt_reg + GW'(1);
      end
      default: ;
    endcase
  end

  assign busy       = busy_reg;
  assign frame_done = fd_reg;
  assign CS         = cs_reg;
  assign SCLK       = sclk_reg;
  assign SerialData = sdo_reg;

`ifdef DAC_SPI_LDAC_EN
  logic ldac_reg, ldac_next;

  // Low for DIV cycles starting the cycle after CS rises.
  assign ldac_next = !((state_reg == S_GAP) && (gcnt_reg < GW'(DIV)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ldac_reg <= 1'b1;
    else     ldac_reg <= ldac_next;
  end

  assign LDAC = ldac_reg;
`endif

endmodule
